// File: rtl/alu_bank_4b.sv
// rtl/alu_bank_4b.sv - action-stage array of 64 32-bit ALUs feeding a 2-entry PHV output FIFO
// Results are computed combinationally into the FIFO write port; the head is re-registered onto phv_out.
module alu_bank_4b #(
   parameter int STAGE_ID   = 0,
   parameter int PHV_LEN    = 4*8*64+256,
   parameter int ACT_LEN    = 64,
   parameter int C_NUM_PHVS = 64+1,
   parameter int width_4B   = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_in_valid,
   input  logic [width_4B*64-1:0]        alu_in_4B_1,
   input  logic [width_4B*64-1:0]        alu_in_4B_2,
   input  logic [width_4B*64-1:0]        alu_in_4B_3,
   input  logic [255:0]                  phv_remain_data,
   input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
   input  logic                          action_in_valid,
   output logic                          ready_out,
   output logic [PHV_LEN-1:0]            phv_out,
   output logic                          phv_out_valid,
   input  logic                          ready_in,
   output logic                          overflow
);

   localparam int OP_LSB = ACT_LEN - 8;

   logic [width_4B*64-1:0] alu_res;
   logic [OP_LSB-1:0]      unused_acc;
   logic                   unused_bits;
   logic [7:0]             op;
   logic [width_4B-1:0]    a, b, c;

   always_comb begin
      alu_res    = '0;
      unused_acc = '0;
      op         = '0;
      a          = '0;
      b          = '0;
      c          = '0;
      for (int i = 0; i < 64; i++) begin
         op = action_in[(i+1)*ACT_LEN + OP_LSB +: 8];
         a  = alu_in_4B_1[width_4B*i +: width_4B];
         b  = alu_in_4B_2[width_4B*i +: width_4B];
         c  = alu_in_4B_3[width_4B*i +: width_4B];
         unused_acc = unused_acc ^ action_in[(i+1)*ACT_LEN +: OP_LSB];
         case (op)
            8'h01, 8'h09: alu_res[width_4B*i +: width_4B] = a + b;
            8'h02, 8'h0A: alu_res[width_4B*i +: width_4B] = a - b;
            8'h0E:        alu_res[width_4B*i +: width_4B] = b;
            8'h07:        alu_res[width_4B*i +: width_4B] = a & b;
            8'h08:        alu_res[width_4B*i +: width_4B] = a | b;
            8'h0B:        alu_res[width_4B*i +: width_4B] = (a > b) ? a : b;
            default:      alu_res[width_4B*i +: width_4B] = c;
         endcase
      end
   end

   // Slot 0 and the non-opcode bits of each action slot carry nothing for this stage.
   assign unused_bits = ^{unused_acc, action_in[ACT_LEN-1:0], 1'(STAGE_ID)};

   logic [PHV_LEN-1:0] wdata;
   assign wdata = {alu_res, phv_remain_data};

   logic [PHV_LEN-1:0] mem_q [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;
   logic               valid_q, ready_q, ovf_q, ovf_d;
   logic [PHV_LEN-1:0] phv_q, phv_d;
   logic               accept, pop, push;

   always_comb begin
      accept   = alu_in_valid & action_in_valid;
      pop      = valid_q & ready_in;
      push     = accept & ((count_q != 2'd2) | pop);
      count_d  = count_q + 2'(push) - 2'(pop);
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      ovf_d    = ovf_q | (accept & ~push);
      // Next head is either already stored or is the beat being written right now.
      if (count_d == 2'd0)
         phv_d = '0;
      else if (push && (wr_ptr_q == rd_ptr_d))
         phv_d = wdata;
      else
         phv_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
         ovf_q    <= 1'b0;
         phv_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= (count_d != 2'd0);
         ready_q  <= (count_d == 2'd0);
         ovf_q    <= ovf_d;
         phv_q    <= phv_d;
      end
   end

   assign phv_out       = phv_q;
   assign phv_out_valid = valid_q;
   assign ready_out     = ready_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_alu_bank_4b.sv
// tb/tb_alu_bank_4b.sv - directed-vector scoreboard bench for alu_bank_4b
module tb_alu_bank_4b;
   localparam int PHV_LEN = 2304;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                alu_in_valid = 1'b0;
   logic                action_in_valid = 1'b0;
   logic                ready_in = 1'b0;
   logic [2047:0]       a_v = '0, b_v = '0, c_v = '0;
   logic [255:0]        tail_v = '0;
   logic [64*65-1:0]    act_v = '0;
   logic [PHV_LEN-1:0]  exp_v = '0;
   logic                ready_out, phv_out_valid, overflow;
   logic [PHV_LEN-1:0]  phv_out;

   logic [PHV_LEN-1:0]  sb_q [$];
   int                  errors = 0;
   int                  checks = 0;

   always #5 clk = ~clk;

   alu_bank_4b dut (
      .clk(clk), .rst_n(rst_n), .alu_in_valid(alu_in_valid),
      .alu_in_4B_1(a_v), .alu_in_4B_2(b_v), .alu_in_4B_3(c_v),
      .phv_remain_data(tail_v), .action_in(act_v), .action_in_valid(action_in_valid),
      .ready_out(ready_out), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
      .ready_in(ready_in), .overflow(overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && phv_out_valid && ready_in) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got a valid output, expected none");
         end else begin
            logic [PHV_LEN-1:0] e;
            e = sb_q.pop_front();
            if (phv_out !== e) begin
               errors++;
               for (int k = 0; k < PHV_LEN/32; k++) begin
                  if (phv_out[32*k +: 32] !== e[32*k +: 32]) begin
                     $display("FAIL phv_word%0d: got %08h expected %08h", k, phv_out[32*k +: 32], e[32*k +: 32]);
                     break;
                  end
               end
            end
         end
      end
   end

   task automatic new_vec(input logic [255:0] tail);
      for (int i = 0; i < 64; i++) begin
         c_v[32*i +: 32] = 32'hC0DE0000 | 32'(i);
         a_v[32*i +: 32] = 32'h11110000 | 32'(i);
         b_v[32*i +: 32] = 32'h22220000 | 32'(i);
      end
      act_v        = '0;
      act_v[63:0]  = '1;
      tail_v       = tail;
      exp_v        = {c_v, tail};
   endtask

   task automatic set_op(input int i, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [31:0] res);
      act_v[(i+1)*64 + 56 +: 8] = op;
      act_v[(i+1)*64 +: 56]     = 56'h5A5A5A5A5A5A5A;
      a_v[32*i +: 32]           = a;
      b_v[32*i +: 32]           = b;
      c_v[32*i +: 32]           = c;
      exp_v[256 + 32*i +: 32]   = res;
   endtask

   task automatic issue(input bit av, input bit cv, input bit expect_push);
      alu_in_valid    = av;
      action_in_valid = cv;
      @(posedge clk);
      #1;
      alu_in_valid    = 1'b0;
      action_in_valid = 1'b0;
      if (expect_push)
         sb_q.push_back(exp_v);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the caller at the first negedge where phv_out_valid is low.
   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (!phv_out_valid) break;
         k++;
      end
      if (k == 20) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got valid still high after 20 cycles, expected drain", name);
      end
   endtask

   logic [7:0]  ops [4] = '{8'h0E, 8'h07, 8'h08, 8'h0B};
   logic [31:0] ress[4] = '{32'h00FF00FF, 32'h000F0000, 32'h0FFF00FF, 32'h0F0F0000};

   initial begin
      new_vec(256'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_valid", 32'(phv_out_valid), 32'd0);
      check("reset_ready", 32'(ready_out), 32'd1);
      check("reset_ovf", 32'(overflow), 32'd0);
      check("reset_phv_zero", 32'(|phv_out), 32'd0);
      @(posedge clk); #1;

      // add/sub wrap and pass-through
      ready_in = 1'b1;
      new_vec(256'hABCD);
      set_op(5, 8'h01, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h00000001);
      set_op(6, 8'h02, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF);
      set_op(7, 8'h00, 32'h12345678, 32'h9, 32'hDEADBEEF, 32'hDEADBEEF);
      issue(1, 1, 1);
      check("latency_valid", 32'(phv_out_valid), 32'd1);
      check("ready_out_one_held", 32'(ready_out), 32'd0);
      idle(2);

      // set/and/or/max back to back, edge containers on the first beat
      for (int k = 0; k < 4; k++) begin
         new_vec(256'h1000 + 256'(k));
         set_op(0, ops[k], 32'h0F0F0000, 32'h00FF00FF, 32'hCCCC0000, ress[k]);
         if (k == 0) begin
            set_op(63, 8'h09, 32'h10, 32'h20, 32'h0, 32'h30);
            set_op(62, 8'h0A, 32'h5, 32'h7, 32'h0, 32'hFFFFFFFE);
            set_op(1, 8'h03, 32'h1, 32'h2, 32'h13572468, 32'h13572468);
         end
         issue(1, 1, 1);
      end
      idle(2);

      // mismatched valids must not write
      new_vec(256'h2000);
      issue(1, 0, 0);
      issue(0, 1, 0);
      idle(1);
      check("half_valid_drop", 32'(phv_out_valid), 32'd0);

      // full FIFO with simultaneous pop and push
      ready_in = 1'b0;
      new_vec(256'h5001); issue(1, 1, 1);
      new_vec(256'h5002); issue(1, 1, 1);
      check("full_ready_out", 32'(ready_out), 32'd0);
      ready_in = 1'b1;
      new_vec(256'h5003);
      set_op(10, 8'h01, 32'h1, 32'h1, 32'h0, 32'h2);
      issue(1, 1, 1);
      wait_drain("pushpop");
      check("pushpop_no_ovf", 32'(overflow), 32'd0);
      check("pushpop_sb_empty", 32'(sb_q.size()), 32'd0);
      @(posedge clk); #1;

      // overflow on third beat under backpressure
      ready_in = 1'b0;
      new_vec(256'h6001); issue(1, 1, 1);
      check("ready_out_after_first", 32'(ready_out), 32'd0);
      new_vec(256'h6002); issue(1, 1, 1);
      check("ovf_before_third", 32'(overflow), 32'd0);
      new_vec(256'h6003); issue(1, 1, 0);
      check("ovf_set", 32'(overflow), 32'd1);
      idle(2);
      ready_in = 1'b1;
      wait_drain("overflow");
      check("ready_out_after_drain", 32'(ready_out), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_sb_empty", 32'(sb_q.size()), 32'd0);
      @(posedge clk); #1;

      // reset while two entries are held
      ready_in = 1'b0;
      new_vec(256'h7001); issue(1, 1, 1);
      new_vec(256'h7002); issue(1, 1, 1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_valid", 32'(phv_out_valid), 32'd0);
      check("reset_clears_ovf", 32'(overflow), 32'd0);
      sb_q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ready", 32'(ready_out), 32'd1);
      check("post_reset_valid", 32'(phv_out_valid), 32'd0);
      @(posedge clk); #1;
      ready_in = 1'b1;
      idle(4);
      new_vec(256'h8001);
      set_op(20, 8'h0B, 32'h5, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
      issue(1, 1, 1);
      idle(3);
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

endmodule

// File: doc/alu_bank_4b.md
Name: alu_bank_4b

Overview:
- Action-stage ALU array directly downstream of the per-stage crossbar.
- Takes the crossbar's three 64-container operand buses, its 1-cycle-delayed action word and the untouched 256-bit PHV tail.
- Runs 64 parallel 32-bit ALUs, reassembles the full PHV and hands it to the next stage through a 2-entry output FIFO.
- The FIFO absorbs the crossbar's one-beat reaction latency to backpressure.

Parameters:
STAGE_ID, 0, stage index; no functional effect, kept for hierarchy naming.
PHV_LEN, 4*8*64+256, total PHV width (2304).
ACT_LEN, 64, per-container action word width.
C_NUM_PHVS, 64+1, action slots per action bus; slot 0 is unused here.
width_4B, 32, container width.

Ports:
clk  input  1  stage clock.
rst_n  input  1  reset; asynchronous, active-low.
alu_in_valid  input  1  one operand beat per cycle high.
alu_in_4B_1  input  width_4B*64  operand A; container i at [32*i +: 32].
alu_in_4B_2  input  width_4B*64  operand B, same layout.
alu_in_4B_3  input  width_4B*64  original container values, same layout.
phv_remain_data  input  256  metadata tail, passed through.
action_in  input  ACT_LEN*65  action bus; container i uses slot i+1 at [(i+1)*64 +: 64]; opcode = slot[63:56].
action_in_valid  input  1  qualifies action_in; must equal alu_in_valid, otherwise the beat is dropped.
ready_out  output  1  to crossbar ready_in.
phv_out  output  PHV_LEN  result PHV; container i at [256+32*i +: 32]; tail at [255:0].
phv_out_valid  output  1  phv_out holds the FIFO head.
ready_in  input  1  downstream accepts the head this cycle.
overflow  output  1  sticky; a beat arrived while the FIFO was full.

Behaviour:
- Reset (async, rst_n low): FIFO count=0, rd/wr pointers=0, phv_out_valid=0, phv_out=0, ready_out=1, overflow=0. Stored data are not required to clear.
- Beat accepted at a posedge when alu_in_valid & action_in_valid. If only one of the two is high: no write, no flag.
- Per container i, from opcode op of slot i+1, A = operand A, B = operand B, C = original value:
  - 0x01 add, 0x09 addi: A+B, mod 2^32.
  - 0x02 sub, 0x0A subi: A-B, mod 2^32 (wraps: 0-1 = 0xFFFFFFFF).
  - 0x0E set: B.
  - 0x07: A & B. 0x08: A | B. 0x0B: unsigned max(A,B).
  - Any other op: C, the original container, unchanged.
- Result word = {64 results, phv_remain_data}. It is written into the FIFO in the same cycle it is accepted; the compute is combinational into the FIFO write port.
- Latency: a beat written into an empty FIFO appears on phv_out with phv_out_valid=1 the next cycle.
- FIFO, depth 2:
  - phv_out / phv_out_valid are driven registered from the head entry.
  - Pop when phv_out_valid & ready_in.
  - Pointers wrap modulo 2.
  - Count update: push only +1, pop only -1, simultaneous push and pop = count unchanged. A simultaneous push+pop on a full FIFO is legal and loses nothing.
- ready_out registered: next value = (next count == 0).
  - Deasserts as soon as one entry is held, leaving one slot for the beat the crossbar may already be emitting.
  - Reasserts the cycle after the FIFO drains.
- Overflow: push attempted with count==2 and no pop that cycle -> beat dropped, overflow set, held until reset.
- Reset mid-operation: FIFO contents discarded immediately, phv_out_valid drops asynchronously, no partial output.

Test Plan:
- Reset then idle -> phv_out_valid=0, ready_out=1, overflow=0, phv_out=0.
- Container 5 op 0x01, A=0xFFFFFFFF, B=2; container 6 op 0x02, A=0, B=1; container 7 op 0x00, C=0xDEADBEEF; tail=0xABCD; ready_in=1 -> next cycle:
  - phv_out[256+160 +: 32]=0x00000001.
  - container 6 = 0xFFFFFFFF.
  - container 7 = 0xDEADBEEF.
  - phv_out[255:0]=0xABCD.
- Container 0 ops 0x0E/0x07/0x08/0x0B with A=0x0F0F0000, B=0x00FF00FF -> 0x00FF00FF / 0x000F0000 / 0x0FFF00FF / 0x0F0F0000.
- ready_in=0, three consecutive valid beats -> ready_out falls after the first beat, count reaches 2, third beat dropped, overflow=1. ready_in=1 -> beats 1 and 2 emitted in order; ready_out=1 the cycle after the drain.
- FIFO full, ready_in=1 with a new valid beat in the same cycle -> head popped, new beat stored, overflow stays 0, order preserved.
- rst_n pulsed low while 2 entries are held -> phv_out_valid=0 immediately. After release: ready_out=1 and no stale beat is ever emitted.
